// File: rtl/iter_multdiv_pkg.sv
// Shared types and constants for the iterative 32-bit multiplier/divider.
package iter_multdiv_pkg;

  localparam int          WIDTH      = 32;
  localparam int          MUL_CYCLES = 16;
  localparam int          DIV_CYCLES = 32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    DONE
  } state_t;

endpackage

// File: rtl/booth4_select.sv
// Radix-4 modified Booth partial-product selector: window -> {0, +-M, +-2M}.
module booth4_select
  import iter_multdiv_pkg::*;
(
  input  logic        [2:0]       i_window,
  input  logic signed [WIDTH-1:0] i_mcand,
  output logic signed [WIDTH+1:0] o_pp
);

  // Two guard bits so that -2*INT_MIN is still representable.
  logic signed [WIDTH+1:0] w_m;
  assign w_m = {{2{i_mcand[WIDTH-1]}}, i_mcand};

  always_comb begin
    o_pp = '0;
    case (i_window)
      3'b001, 3'b010: o_pp = w_m;
      3'b011:         o_pp = w_m <<< 1;
      3'b100:         o_pp = -(w_m <<< 1);
      3'b101, 3'b110: o_pp = -w_m;
      default:        o_pp = '0;
    endcase
  end

endmodule

// File: rtl/iter_multdiv.sv
// Sequential signed 32-bit multiplier (radix-4 Booth, 16 cycles) and
// restoring divider (32 cycles) sharing one start/ready handshake.
module iter_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  import iter_multdiv_pkg::*;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  logic [4:0] r_cnt;

  logic w_start;
  logic w_start_mul;
  logic w_start_div;
  logic w_mul_last;
  logic w_div_last;
  logic w_finish;

  logic signed [WIDTH-1:0]   r_mcand;
  logic signed [WIDTH:0]     r_mplier;
  logic signed [2*WIDTH-1:0] r_acc;
  logic signed [WIDTH+1:0]   w_pp;
  logic signed [2*WIDTH-1:0] w_pp_ext;
  logic signed [2*WIDTH-1:0] w_acc_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg;
  logic             r_div_zero;
  logic             r_div_ovf;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  logic [WIDTH-1:0] w_res_nxt;
  logic             w_exc_nxt;

  // Multiply has priority when both strobes arrive together.
  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_start_mul = ctrl_MULT;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;

  assign w_mul_last = (r_state == MUL_RUN) && (r_cnt == MUL_LAST);
  assign w_div_last = (r_state == DIV_RUN) && (r_cnt == DIV_LAST);
  assign w_finish   = (w_mul_last | w_div_last) & ~w_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)
        r_cnt <= '0;
      else if (r_state == MUL_RUN || r_state == DIV_RUN)
        r_cnt <= r_cnt + 5'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MUL_RUN: if (w_mul_last) w_state_nxt = DONE;
      DIV_RUN: if (w_div_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = r_state;
    endcase
    if (w_start_mul)
      w_state_nxt = MUL_RUN;
    else if (w_start_div)
      w_state_nxt = DIV_RUN;
  end

  assign data_resultRDY = (r_state == DONE);

  booth4_select u_booth (
    .i_window (r_mplier[2:0]),
    .i_mcand  (r_mcand),
    .o_pp     (w_pp)
  );

  // Partial product i carries weight 4^i; the 64-bit sum wraps harmlessly.
  assign w_pp_ext  = {{(WIDTH-2){w_pp[WIDTH+1]}}, w_pp};
  assign w_acc_nxt = r_acc + (w_pp_ext <<< {r_cnt[3:0], 1'b0});

  // Remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shifted[WIDTH-1:0] - r_dvsr;
  assign w_ge      = (w_shifted >= {1'b0, r_dvsr});
  assign w_rem_nxt = w_ge ? w_diff : w_shifted[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clock) begin
    if (w_start) begin
      r_mcand    <= data_operandA;
      r_mplier   <= {data_operandB, 1'b0};
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= magnitude(data_operandA);
      r_dvsr     <= magnitude(data_operandB);
      r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_div_zero <= (data_operandB == '0);
      r_div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
    end else if (r_state == MUL_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= r_mplier >>> 2;
    end else if (r_state == DIV_RUN) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  always_comb begin
    w_res_nxt = data_result;
    w_exc_nxt = data_exception;
    if (w_mul_last) begin
      w_res_nxt = w_acc_nxt[WIDTH-1:0];
      w_exc_nxt = (w_acc_nxt[2*WIDTH-1:WIDTH] != {WIDTH{w_acc_nxt[WIDTH-1]}});
    end else if (w_div_last) begin
      if (r_div_zero) begin
        w_res_nxt = '0;
        w_exc_nxt = 1'b1;
      end else begin
        w_res_nxt = apply_sign(w_quo_nxt, r_neg);
        w_exc_nxt = r_div_ovf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (w_finish) begin
      data_result    <= w_res_nxt;
      data_exception <= w_exc_nxt;
    end
  end

endmodule

// File: tb/tb_iter_multdiv.sv
// Directed bench for iter_multdiv: latency, products, quotients, exceptions,
// restart priority and asynchronous reset.
module tb_iter_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  int rdy_cnt;

  always #5 clock = ~clock;

  iter_multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns 1 ns after the start edge with operands scrambled.
  task automatic start_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0000_0000;
  endtask

  // Edges after the start edge until RDY is seen; 0 means it never came.
  task automatic wait_rdy(output int l);
    l = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic mul, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res, input logic exp_exc);
    int l;
    @(negedge clock);
    start_op(mul, ~mul, a, b);
    wait_rdy(l);
    check_eq({tag, ".lat"}, 32'(l), 32'(exp_lat));
    check_eq({tag, ".res"}, data_result, exp_res);
    check_eq({tag, ".exc"}, {31'b0, data_exception}, {31'b0, exp_exc});
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, ".rdy_off"}, {31'b0, data_resultRDY}, 32'd0);
    check_eq({tag, ".hold"}, data_result, exp_res);
  endtask

  initial begin
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    check_eq("rst.rdy", {31'b0, data_resultRDY}, 32'd0);
    check_eq("rst.res", data_result, 32'd0);
    check_eq("rst.exc", {31'b0, data_exception}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("mul_7x-3",     1'b1, 32'd7,          32'hFFFF_FFFD, 16, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_ovf",      1'b1, 32'h0001_0000,  32'h0001_0000, 16, 32'h0000_0000, 1'b1);
    run_op("mul_max",      1'b1, 32'h7FFF_FFFF,  32'd1,         16, 32'h7FFF_FFFF, 1'b0);
    run_op("mul_min_x-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 16, 32'h8000_0000, 1'b1);
    run_op("mul_min_x1",   1'b1, 32'h8000_0000,  32'd1,         16, 32'h8000_0000, 1'b0);
    run_op("mul_-1x-1",    1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 16, 32'd1,         1'b0);
    run_op("div_-7/2",     1'b0, 32'hFFFF_FFF9,  32'd2,         32, 32'hFFFF_FFFD, 1'b0);
    run_op("div_100/-7",   1'b0, 32'd100,        32'hFFFF_FFF9, 32, 32'hFFFF_FFF2, 1'b0);
    run_op("div_-100/-7",  1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32, 32'd14,        1'b0);
    run_op("div_min/2",    1'b0, 32'h8000_0000,  32'd2,         32, 32'hC000_0000, 1'b0);

    // Restart mid-divide with both strobes: multiply wins, divide never reports.
    @(negedge clock);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    start_op(1'b1, 1'b1, 32'd6, 32'd7);
    wait_rdy(lat);
    check_eq("restart.lat", 32'(lat), 32'd16);
    check_eq("restart.res", data_result, 32'd42);
    check_eq("restart.exc", {31'b0, data_exception}, 32'd0);
    rdy_cnt = 0;
    repeat (20) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check_eq("restart.no_div_rdy", 32'(rdy_cnt), 32'd0);

    run_op("div_5/0",      1'b0, 32'd5,          32'd0,         32, 32'd0,         1'b1);
    run_op("div_min/-1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32, 32'h8000_0000, 1'b1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clock);
    start_op(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777);
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst.rdy", {31'b0, data_resultRDY}, 32'd0);
    check_eq("arst.res", data_result, 32'd0);
    check_eq("arst.exc", {31'b0, data_exception}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check_eq("arst.no_rdy", 32'(rdy_cnt), 32'd0);
    check_eq("arst.res_held", data_result, 32'd0);

    run_op("mul_3x4",      1'b1, 32'd3,          32'd4,         16, 32'd12,        1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
